// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the hardwired CPU control unit: the sequencer
// state encoding, the instruction opcodes found in IR[31:27] and the ALU
// operation codes placed on OP.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_HALTED = 4'd8
    } state_t;

    typedef enum logic [4:0] {
        OPC_ADD  = 5'b00011,
        OPC_SUB  = 5'b00100,
        OPC_AND  = 5'b00101,
        OPC_OR   = 5'b00110,
        OPC_MUL  = 5'b01111,
        OPC_DIV  = 5'b10000,
        OPC_HALT = 5'b11011
    } opcode_t;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b01000;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    // Instruction opcodes and ALU codes are not numerically equal (OR and
    // MUL in particular), so the mapping is kept in one place.
    function automatic logic [4:0] aluCode(input logic [4:0] opc);
        case (opc)
            OPC_ADD: aluCode = ALU_ADD;
            OPC_SUB: aluCode = ALU_SUB;
            OPC_AND: aluCode = ALU_AND;
            OPC_OR:  aluCode = ALU_OR;
            OPC_MUL: aluCode = ALU_MUL;
            OPC_DIV: aluCode = ALU_DIV;
            default: aluCode = 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// ---------------------------------------------------------------------------
// control_unit_if
// Bundles the control unit's datapath-facing signals.
//   Run, IR                         : datapath -> control unit
//   Rin/Rout, *in/*out enables,
//   IncPC, Read, OP, Done, Illegal  : control unit -> datapath
// modport master : the control unit side
// modport slave  : the datapath (or testbench) side
// ---------------------------------------------------------------------------
interface control_unit_if;

    logic        Run;
    logic [31:0] IR;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, Yin;
    logic        PCout, HIout, LOout, ZHighout, ZLowout, MDRout;
    logic        IncPC, Read;
    logic [4:0]  OP;
    logic        Done, Illegal;

    modport master (
        input  Run, IR,
        output Rin, Rout,
        output PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, Yin,
        output PCout, HIout, LOout, ZHighout, ZLowout, MDRout,
        output IncPC, Read, OP, Done, Illegal
    );

    modport slave (
        output Run, IR,
        input  Rin, Rout,
        input  PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, Yin,
        input  PCout, HIout, LOout, ZHighout, ZLowout, MDRout,
        input  IncPC, Read, OP, Done, Illegal
    );

endinterface

// File: rtl/control_unit_reg_select.sv
// ---------------------------------------------------------------------------
// reg_select
// 4-to-16 one-hot register decoder with enable.
//   en_i     : when 0 the output is all zeros
//   sel_i    : register number 0..15
//   onehot_o : bit sel_i set when enabled
// ---------------------------------------------------------------------------
module reg_select (
    input  logic        en_i,
    input  logic [3:0]  sel_i,
    output logic [15:0] onehot_o
);

    assign onehot_o = en_i ? (16'h0001 << sel_i) : 16'h0000;

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Hardwired sequencer for a simple bus-based CPU: fetch in T0..T2, then
// decode/execute of ALU, MUL/DIV, HALT or illegal instructions.
//   Clock : rising-edge clock
//   Clear : asynchronous active-low reset, forces IDLE
//   bus   : control_unit_if.master (Run/IR in, all enables/status out)
// Outputs are a combinational decode of the registered state and IR, so an
// asserted Clear zeroes them in the same cycle.
// ---------------------------------------------------------------------------
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic           Clock,
    input  logic           Clear,
    control_unit_if.master bus
);

    state_t     state_q, state_d;
    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic       isAlu, isMulDiv, isHalt;
    logic       rinEn, routEn;
    logic [3:0] rinSel, routSel;
    logic       unusedIrBits;

    assign opc          = bus.IR[31:27];
    assign ra           = bus.IR[26:23];
    assign rb           = bus.IR[22:19];
    assign rc           = bus.IR[18:15];
    assign unusedIrBits = ^bus.IR[14:0];

    assign isAlu    = (opc == OPC_ADD) || (opc == OPC_SUB) ||
                      (opc == OPC_AND) || (opc == OPC_OR);
    assign isMulDiv = (opc == OPC_MUL) || (opc == OPC_DIV);
    assign isHalt   = (opc == OPC_HALT);

    // State register.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: Run is only consulted in IDLE and in whichever state
    // completes the instruction.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = bus.Run ? ST_T0 : ST_IDLE;
            ST_T0:     state_d = ST_T1;
            ST_T1:     state_d = ST_T2;
            ST_T2:     state_d = ST_T3;
            ST_T3: begin
                if (isAlu || isMulDiv) state_d = ST_T4;
                else if (isHalt)       state_d = ST_HALTED;
                else                   state_d = bus.Run ? ST_T0 : ST_IDLE;
            end
            ST_T4:     state_d = ST_T5;
            ST_T5:     state_d = isMulDiv ? ST_T6 : (bus.Run ? ST_T0 : ST_IDLE);
            ST_T6:     state_d = bus.Run ? ST_T0 : ST_IDLE;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode; register numbers are routed to the two one-hot
    // decoders rather than building Rin/Rout here.
    always_comb begin
        rinEn        = 1'b0;
        rinSel       = 4'd0;
        routEn       = 1'b0;
        routSel      = 4'd0;
        bus.PCin     = 1'b0;
        bus.IRin     = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.ZHighin  = 1'b0;
        bus.ZLowin   = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.Yin      = 1'b0;
        bus.PCout    = 1'b0;
        bus.HIout    = 1'b0;
        bus.LOout    = 1'b0;
        bus.ZHighout = 1'b0;
        bus.ZLowout  = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Read     = 1'b0;
        bus.OP       = 5'b00000;
        bus.Done     = 1'b0;
        bus.Illegal  = 1'b0;
        case (state_q)
            ST_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
            end
            ST_T1: begin
                bus.PCin  = 1'b1;
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
            end
            ST_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            ST_T3: begin
                if (isAlu) begin
                    routEn  = 1'b1;
                    routSel = rb;
                    bus.Yin = 1'b1;
                end else if (isMulDiv) begin
                    routEn  = 1'b1;
                    routSel = ra;
                    bus.Yin = 1'b1;
                end else if (isHalt) begin
                    bus.Done = 1'b1;
                end else begin
                    bus.Illegal = 1'b1;
                    bus.Done    = 1'b1;
                end
            end
            ST_T4: begin
                if (isAlu || isMulDiv) begin
                    routEn     = 1'b1;
                    routSel    = isAlu ? rc : rb;
                    bus.ZLowin = 1'b1;
                    bus.ZHighin = isMulDiv;
                    bus.OP     = aluCode(opc);
                end
            end
            ST_T5: begin
                bus.ZLowout = 1'b1;
                if (isMulDiv) begin
                    bus.LOin = 1'b1;
                end else begin
                    rinEn    = 1'b1;
                    rinSel   = ra;
                    bus.Done = 1'b1;
                end
            end
            ST_T6: begin
                bus.ZHighout = 1'b1;
                bus.HIin     = 1'b1;
                bus.Done     = 1'b1;
            end
            default: ;
        endcase
    end

    reg_select uRinSel (
        .en_i     (rinEn),
        .sel_i    (rinSel),
        .onehot_o (bus.Rin)
    );

    reg_select uRoutSel (
        .en_i     (routEn),
        .sel_i    (routSel),
        .onehot_o (bus.Rout)
    );

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock, input, 1, the single rising-edge clock for all state.
REQ-002 SHALL have port Clear, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Run, input, 1, a level that enables instruction sequencing.
REQ-004 SHALL have port IR, input, 32, the instruction from the datapath IR: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
REQ-005 SHALL have ports Rin and Rout, output, 16 each, one-hot register load and drive enables (bit n = Rn).
REQ-006 SHALL have ports PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin and Yin, output, 1 each, datapath load enables.
REQ-007 SHALL have ports PCout, HIout, LOout, ZHighout, ZLowout and MDRout, output, 1 each, bus drive enables.
REQ-008 SHALL have ports IncPC and Read, output, 1 each, PC increment and memory read.
REQ-009 SHALL have port OP, output, 5, the ALU operation select.
REQ-010 SHALL have ports Done and Illegal, output, 1 each, one-cycle status pulses.

Function
REQ-011 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6 and HALTED, advancing one state per rising Clock edge.
REQ-012 SHALL decode all outputs combinationally from the registered state and IR; every output defaults to 0.
REQ-013 IDLE: all outputs 0; move to T0 when Run=1.
REQ-014 T0: PCout, MARin, IncPC=1.
REQ-015 T1: PCin, Read, MDRin=1.
REQ-016 T2: MDRout, IRin=1; T3 decodes the IR loaded at the end of T2.
REQ-017 ADD/SUB/AND/OR:
- T3: Rout[rb], Yin.
- T4: Rout[rc], ZLowin, OP=alu code.
- T5: ZLowout, Rin[ra], Done.
REQ-018 MUL/DIV:
- T3: Rout[ra], Yin.
- T4: Rout[rb], ZLowin, ZHighin, OP=00110 (MUL) or 00111 (DIV).
- T5: ZLowout, LOin.
- T6: ZHighout, HIin, Done.
REQ-019 HALT opcode (11011): in T3 assert Done and move to HALTED; HALTED holds, with all outputs 0, until Clear.
REQ-020 Unrecognised opcode in T3: pulse Illegal and Done, with no register or Z enables.
REQ-021 After the Done state: go to T0 if Run=1, else IDLE; Run is sampled only at IDLE and at Done states.
REQ-022 Exactly one bit of Rin and of Rout SHALL be set when that enable is active; Rin[0] is permitted (R0 is writable).
REQ-023 Instruction latency: 6 cycles for ALU/HALT-free ops, 7 for MUL/DIV.

Reset
REQ-024 Clear=0 SHALL immediately force state IDLE and all outputs to 0, including mid-instruction; no partial register write occurs after assertion.
REQ-025 After Clear deasserts, sequencing restarts at T0 on the first edge with Run=1.

Structure
REQ-026 Shared package cpu_ctrl_pkg SHALL hold the state enum, instruction opcodes (ADD 00011, SUB 00100, AND 00101, OR 00110, MUL 01111, DIV 10000, HALT 11011) and ALU codes (ADD 00011, SUB 00100, AND 00101, OR 01000, MUL 00110, DIV 00111).
REQ-027 A sub-module reg_select SHALL perform the 4-to-16 one-hot decode with an enable; it is instantiated for Rin and Rout.

Verification
REQ-028 Run=1, IR=0x7B380000 (MUL R6,R7):
- T3 Rout=0x0040, Yin.
- T4 Rout=0x0080, OP=00110, ZLowin, ZHighin.
- T5 ZLowout, LOin.
- T6 ZHighout, HIin, Done.
REQ-029 IR=0x191A0000 (ADD R2,R3,R4):
- T3 Rout=0x0008.
- T4 Rout=0x0010, OP=00011.
- T5 Rin=0x0004, Done; 6 cycles total.
REQ-030 IR opcode 11111 -> Illegal and Done pulse in T3; Rin=0, ZLowin=0; next state T0.
REQ-031 Clear pulled low during T4 of MUL -> all outputs 0 within the same cycle; state IDLE; no LOin/HIin afterwards.
REQ-032 Run dropped during an ADD -> instruction completes, then IDLE; Run=1 again -> T0 next edge.
REQ-033 IR opcode 11011 -> Done in T3, then HALTED with all outputs 0 for 20 cycles despite Run=1.
